// File: rtl/ants_pair_packer.sv
// rtl/ants_pair_packer.sv - pairs a serial per-RE antenna stream into even/odd lanes for the beam combiner
//
// Ports:
//   i_clk, i_reset          clock (rising edge), asynchronous active-high reset
//   i_ants_data             one RE, all ANT antennas, IW bits each
//   i_rvalid, i_sop, i_eop  input beat valid and packet framing (sop/eop qualified by i_rvalid)
//   o_ants_data_even/odd    paired REs; odd lane is zero when the pair is padded
//   o_rvalid                one-cycle pulse per emitted pair
//   o_sop, o_eop, o_pad     pair framing and padding flag, only with o_rvalid
//   o_pair_cnt              pair index within packet, valid with o_rvalid
//   o_err                   [0] sop mid-packet, [1] valid beat outside a packet
module ants_pair_packer #(
    parameter int ANT = 32,
    parameter int IW  = 32,
    parameter int CW  = 11
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [ANT*IW-1:0]   i_ants_data,
    input  logic                i_rvalid,
    input  logic                i_sop,
    input  logic                i_eop,
    output logic [ANT*IW-1:0]   o_ants_data_even,
    output logic [ANT*IW-1:0]   o_ants_data_odd,
    output logic                o_rvalid,
    output logic                o_sop,
    output logic                o_eop,
    output logic                o_pad,
    output logic [CW-1:0]       o_pair_cnt,
    output logic [1:0]          o_err
);

    localparam int DW = ANT * IW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_EVEN = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   hold_q, hold_d;
    logic            first_q, first_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   even_q, even_d;
    logic [DW-1:0]   odd_q, odd_d;
    logic            rvalid_q, rvalid_d;
    logic            sop_q, sop_d;
    logic            eop_q, eop_d;
    logic            pad_q, pad_d;
    logic [CW-1:0]   pcnt_q, pcnt_d;
    logic [1:0]      err_q, err_d;

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        first_d  = first_q;
        cnt_d    = cnt_q;
        even_d   = even_q;
        odd_d    = odd_q;
        pcnt_d   = pcnt_q;
        rvalid_d = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        pad_d    = 1'b0;
        err_d    = 2'b00;

        if (i_rvalid) begin
            if (i_sop) begin
                // A sop always restarts the packet; anything held from an
                // aborted packet is simply overwritten or abandoned.
                if (state_q != S_IDLE) begin
                    err_d[0] = 1'b1;
                end
                cnt_d = '0;
                if (i_eop) begin
                    even_d   = i_ants_data;
                    odd_d    = '0;
                    rvalid_d = 1'b1;
                    sop_d    = 1'b1;
                    eop_d    = 1'b1;
                    pad_d    = 1'b1;
                    pcnt_d   = '0;
                    first_d  = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    hold_d  = i_ants_data;
                    first_d = 1'b1;
                    state_d = S_HOLD;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        err_d[1] = 1'b1;
                    end
                    S_HOLD: begin
                        even_d   = hold_q;
                        odd_d    = i_ants_data;
                        rvalid_d = 1'b1;
                        sop_d    = first_q;
                        eop_d    = i_eop;
                        pcnt_d   = cnt_q;
                        cnt_d    = cnt_q + 1'b1;
                        first_d  = 1'b0;
                        state_d  = i_eop ? S_IDLE : S_EVEN;
                    end
                    S_EVEN: begin
                        if (i_eop) begin
                            even_d   = i_ants_data;
                            odd_d    = '0;
                            rvalid_d = 1'b1;
                            eop_d    = 1'b1;
                            pad_d    = 1'b1;
                            pcnt_d   = cnt_q;
                            cnt_d    = cnt_q + 1'b1;
                            state_d  = S_IDLE;
                        end else begin
                            hold_d  = i_ants_data;
                            state_d = S_HOLD;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            hold_q   <= '0;
            first_q  <= 1'b0;
            cnt_q    <= '0;
            even_q   <= '0;
            odd_q    <= '0;
            rvalid_q <= 1'b0;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            pad_q    <= 1'b0;
            pcnt_q   <= '0;
            err_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            first_q  <= first_d;
            cnt_q    <= cnt_d;
            even_q   <= even_d;
            odd_q    <= odd_d;
            rvalid_q <= rvalid_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            pad_q    <= pad_d;
            pcnt_q   <= pcnt_d;
            err_q    <= err_d;
        end
    end

    assign o_ants_data_even = even_q;
    assign o_ants_data_odd  = odd_q;
    assign o_rvalid         = rvalid_q;
    assign o_sop            = sop_q;
    assign o_eop            = eop_q;
    assign o_pad            = pad_q;
    assign o_pair_cnt       = pcnt_q;
    assign o_err            = err_q;

endmodule

// File: tb/tb_ants_pair_packer.sv
// tb/tb_ants_pair_packer.sv - randomized and directed self-checking bench for ants_pair_packer
module tb_ants_pair_packer;

    localparam int ANT = 32;
    localparam int IW  = 32;
    localparam int CW  = 11;
    localparam int DW  = ANT * IW;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b0;
    logic [DW-1:0]   i_ants_data = '0;
    logic            i_rvalid = 1'b0;
    logic            i_sop = 1'b0;
    logic            i_eop = 1'b0;
    logic [DW-1:0]   o_ants_data_even;
    logic [DW-1:0]   o_ants_data_odd;
    logic            o_rvalid;
    logic            o_sop;
    logic            o_eop;
    logic            o_pad;
    logic [CW-1:0]   o_pair_cnt;
    logic [1:0]      o_err;

    ants_pair_packer #(.ANT(ANT), .IW(IW), .CW(CW)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_ants_data      (i_ants_data),
        .i_rvalid         (i_rvalid),
        .i_sop            (i_sop),
        .i_eop            (i_eop),
        .o_ants_data_even (o_ants_data_even),
        .o_ants_data_odd  (o_ants_data_odd),
        .o_rvalid         (o_rvalid),
        .o_sop            (o_sop),
        .o_eop            (o_eop),
        .o_pad            (o_pad),
        .o_pair_cnt       (o_pair_cnt),
        .o_err            (o_err)
    );

    always #5 i_clk = ~i_clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        int wi;
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            wi = 0;
            for (int w = 0; w < DW / 32; w++) begin
                if (obs[w*32 +: 32] !== exp[w*32 +: 32]) begin
                    wi = w;
                    break;
                end
            end
            $display("FAIL %s @%0t: word %0d got %h expected %h", tag, $time, wi,
                     obs[wi*32 +: 32], exp[wi*32 +: 32]);
        end
    endtask

    // Reference model: a packet is a list of REs; every second RE closes a pair,
    // an eop with one RE left over closes a padded pair.
    bit              in_pkt = 1'b0;
    logic [DW-1:0]   pend[$];
    int              npairs = 0;
    bit              exp_v, exp_sop, exp_eop, exp_pad;
    logic [CW-1:0]   exp_cnt = '0;
    logic [1:0]      exp_err;
    logic [DW-1:0]   exp_even = '0;
    logic [DW-1:0]   exp_odd = '0;

    task automatic emit(input logic [DW-1:0] e, input logic [DW-1:0] o, input bit s, input bit ep, input bit p);
        exp_v    = 1'b1;
        exp_even = e;
        exp_odd  = o;
        exp_sop  = s;
        exp_eop  = ep;
        exp_pad  = p;
        exp_cnt  = CW'(npairs % (1 << CW));
        npairs++;
    endtask

    task automatic model_step(input bit v, input bit s, input bit e, input logic [DW-1:0] d);
        exp_v = 0; exp_sop = 0; exp_eop = 0; exp_pad = 0; exp_err = 2'b00;
        if (!v) return;
        if (s) begin
            if (in_pkt) exp_err[0] = 1'b1;
            in_pkt = 1'b1;
            pend.delete();
            npairs = 0;
            pend.push_back(d);
            if (e) begin
                emit(d, '0, 1'b1, 1'b1, 1'b1);
                in_pkt = 1'b0;
                pend.delete();
            end
        end else if (!in_pkt) begin
            exp_err[1] = 1'b1;
        end else begin
            pend.push_back(d);
            if (pend.size() == 2) begin
                emit(pend[0], pend[1], npairs == 0, e, 1'b0);
                pend.delete();
            end else if (e) begin
                emit(pend[0], '0, npairs == 0, 1'b1, 1'b1);
                pend.delete();
            end
            if (e) in_pkt = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("rvalid", o_rvalid, exp_v);
        check("err", o_err, exp_err);
        check("sop", o_sop, exp_sop);
        check("eop", o_eop, exp_eop);
        check("pad", o_pad, exp_pad);
        check("even", o_ants_data_even, exp_even);
        check("odd", o_ants_data_odd, exp_odd);
        if (exp_v) check("pair_cnt", o_pair_cnt, exp_cnt);
    endtask

    task automatic apply(input bit v, input bit s, input bit e, input logic [DW-1:0] d);
        i_rvalid    = v;
        i_sop       = s;
        i_eop       = e;
        i_ants_data = d;
        model_step(v, s, e, d);
        @(posedge i_clk);
        #1;
        compare_all();
    endtask

    function automatic logic [DW-1:0] fill(input logic [31:0] k);
        logic [DW-1:0] r;
        for (int i = 0; i < ANT; i++) r[i*IW +: IW] = k;
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(1'b0, 1'b0, 1'b0, rnd());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rvalid"}, o_rvalid, 1'b0);
        check({tag, "_flags"}, {o_sop, o_eop, o_pad, o_err}, 5'b0);
        check({tag, "_even"}, o_ants_data_even, '0);
        check({tag, "_odd"}, o_ants_data_odd, '0);
        check({tag, "_cnt"}, o_pair_cnt, '0);
    endtask

    initial begin
        exp_err = 2'b00;
        #2 i_reset = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge i_clk);
        i_reset = 1'b0;

        // 8-RE packet, continuous valid
        for (int k = 1; k <= 8; k++) apply(1'b1, k == 1, k == 8, fill(k));
        idle(2);

        // 3-RE packet, padded tail
        for (int k = 1; k <= 3; k++) apply(1'b1, k == 1, k == 3, fill(k));
        idle(1);

        // single-beat packet
        apply(1'b1, 1'b1, 1'b1, fill(32'hA5));
        idle(1);

        // 4-RE packet with 3-cycle gaps
        apply(1'b1, 1'b1, 1'b0, fill(1)); idle(3);
        apply(1'b1, 1'b0, 1'b0, fill(2)); idle(3);
        apply(1'b1, 1'b0, 1'b0, fill(3));
        apply(1'b1, 1'b0, 1'b1, fill(4));
        idle(1);

        // sop on RE3 restarts the packet
        for (int k = 1; k <= 4; k++) apply(1'b1, k == 1 || k == 3, k == 4, fill(k));
        idle(1);

        // stray beats outside a packet
        apply(1'b1, 1'b0, 1'b0, fill(9));
        apply(1'b1, 1'b0, 1'b1, fill(10));
        idle(1);

        // reset while holding an even RE
        apply(1'b1, 1'b1, 1'b0, fill(5));
        apply(1'b1, 1'b0, 1'b0, fill(6));
        apply(1'b1, 1'b1, 1'b0, fill(7));
        i_rvalid = 1'b0;
        #2 i_reset = 1'b1;
        in_pkt = 1'b0; pend.delete(); npairs = 0;
        exp_even = '0; exp_odd = '0; exp_cnt = '0;
        #1 check_reset_outputs("mid_reset");
        @(negedge i_clk);
        i_reset = 1'b0;
        idle(1);
        apply(1'b1, 1'b1, 1'b0, fill(11));
        apply(1'b1, 1'b0, 1'b1, fill(12));
        idle(1);

        // long packet: pair counter wraps past 2^CW
        for (int k = 0; k < 4102; k++) apply(1'b1, k == 0, k == 4101, rnd());
        idle(1);

        // random framing, gaps and errors
        for (int k = 0; k < 3000; k++)
            apply($urandom_range(0, 3) != 0, ($urandom % 6) == 0, ($urandom % 5) == 0, rnd());
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ants_pair_packer.md
Name: ants_pair_packer

Overview:
- Transmit-side feeder for the beam MAC array.
- Takes a serial per-RE antenna stream (one RE of all ANT antennas per valid beat, sop/eop framed) and pairs consecutive REs into even/odd lanes.
- Drives the paired lanes to the beam combiner with rvalid/sop/eop framing.
- Handles odd-length packets by zero-padding, tolerates valid gaps, and flags framing errors.

Parameters:
- ANT, 32, antennas per RE.
- IW, 32, bits per antenna sample (packed I/Q).
- CW, 11, width of output pair counter.

Ports:
- i_clk  input  1  clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_ants_data  input  ANT*IW  one RE, all antennas.
- i_rvalid  input  1  input beat valid.
- i_sop  input  1  first RE of packet; qualified by i_rvalid.
- i_eop  input  1  last RE of packet; qualified by i_rvalid.
- o_ants_data_even  output  ANT*IW  even-indexed RE (0,2,4..) of pair.
- o_ants_data_odd  output  ANT*IW  odd-indexed RE (1,3,5..); zero when padded.
- o_rvalid  output  1  pair valid, single-cycle pulse per pair.
- o_sop  output  1  first pair of packet; only with o_rvalid.
- o_eop  output  1  last pair of packet; only with o_rvalid.
- o_pad  output  1  odd lane is zero padding; only with o_rvalid.
- o_pair_cnt  output  CW  pair index within packet, valid with o_rvalid.
- o_err  output  2  1-cycle pulses. Bit0: sop received mid-packet. Bit1: valid beat outside packet without sop.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; held-RE register 0; first-pair flag 0; pair counter 0.
- All outputs are registered. A pair appears exactly 1 cycle after the input beat that completes it.
- When o_rvalid=0, data outputs hold their last value. o_sop/o_eop/o_pad/o_err are 0.
- Beats with i_rvalid=0 are ignored. Gaps of any length are allowed anywhere and do not change state.
- State IDLE (no packet):
  - valid&sop&!eop: capture RE into hold register, set first-pair flag, go HOLD.
  - valid&sop&eop: next cycle emit even=RE, odd=0, o_sop=o_eop=o_pad=1, o_pair_cnt=0; stay IDLE.
  - valid&!sop: drop beat, pulse o_err[1], stay IDLE.
- State HOLD (even RE held):
  - valid&!sop: next cycle emit even=held, odd=input, o_sop=first-pair flag, o_eop=i_eop, o_pad=0. Clear first-pair flag.
  - Then go IDLE if i_eop, else go EVEN.
- State EVEN (in packet, nothing held):
  - valid&!sop&!eop: capture RE, go HOLD.
  - valid&!sop&eop: next cycle emit even=RE, odd=0, o_pad=1, o_eop=1, o_sop=0; go IDLE.
- Mid-packet sop (valid&sop in HOLD or EVEN):
  - Pulse o_err[0]. Any held RE is discarded; no eop is emitted for the aborted packet.
  - The beat is then processed exactly as an IDLE sop beat (including the sop&eop case).
- o_pair_cnt: 0 on the sop pair, +1 per emitted pair within the packet. Wraps modulo 2^CW with no flag.
- i_eop without a prior sop is covered by the IDLE rule: dropped, o_err[1].
- Asynchronous reset mid-packet: state, held RE and outputs clear immediately; no eop is generated. After release, the first valid beat must carry sop.
- No backpressure. Downstream must accept one pair per cycle. Input may be valid every cycle, giving an output rate of at most 1 pair per 2 cycles.

Test Plan:
- 8-RE packet, REs with value k in every antenna slot (k=1..8), i_rvalid continuous -> 4 pairs (1,2),(3,4),(5,6),(7,8). Each appears 1 cycle after the odd RE. o_sop on pair 0 only, o_eop on pair 3 only, o_pair_cnt 0..3, o_pad=0.
- 3-RE packet (1,2,3) -> pair (1,2) sop=1, cnt=0; then pair (3,0) eop=1, pad=1, cnt=1, 1 cycle after RE 3.
- Single beat with sop=eop=1, value 0xA5 per slot -> one pair: even=0xA5.., odd=0, sop=eop=pad=1, cnt=0. State returns to IDLE.
- 4-RE packet with i_rvalid low for 3 cycles between RE1/RE2 and between RE2/RE3 -> same 2 pairs as the gapless case. No o_rvalid during gaps.
- Framing errors:
  - Sop on RE3 of a packet -> o_err[0] pulse, RE3 starts a new packet with o_pair_cnt reset to 0.
  - Valid beat in IDLE without sop -> o_err[1] pulse, no o_rvalid.
- Assert i_reset while in HOLD -> all outputs 0 immediately, no pending pair emitted. A subsequent 2-RE packet produces a single sop+eop pair.
